// File: rtl/voting_machine.sv
// Four-candidate booth vote counter: debounced one-vote-per-press counting in voting mode, tally display in result mode.
// Optional macro VOTING_TOTAL_EN: result mode with candidate 4'b0000 shows the saturated sum of all four tallies.
module voting_machine #(
   parameter int HOLD_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] candidate,
   input  logic       mode,
   input  logic       button,
   output logic [7:0] led_1,
   output logic [7:0] led_2
);

   localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   logic [3:0][7:0] cnt_q, cnt_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic            voted_q, voted_d;
   logic            lock_q, lock_d;
   logic [3:0]      cand_prev_q, cand_prev_d;
   logic [7:0]      led_1_q, led_1_d;
   logic [7:0]      led_2_q, led_2_d;
   logic            cand_ok;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic is_one_hot(input logic [3:0] c);
      return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
   endfunction

`ifdef VOTING_TOTAL_EN
   function automatic logic [7:0] sat_total(input logic [3:0][7:0] c);
      logic [9:0] sum;
      sum = {2'b00, c[0]} + {2'b00, c[1]} + {2'b00, c[2]} + {2'b00, c[3]};
      return (sum > 10'd255) ? 8'hFF : sum[7:0];
   endfunction
`endif

   assign cand_ok = is_one_hot(candidate);

   always_comb begin
      cnt_d       = cnt_q;
      hold_d      = '0;
      voted_d     = voted_q;
      lock_d      = lock_q;
      cand_prev_d = candidate;
      led_1_d     = 8'h00;
      led_2_d     = 8'h00;
      if (mode) begin
         // A button held across a mode change must be released before it can vote again.
         voted_d = 1'b0;
         lock_d  = button;
         for (int i = 0; i < 4; i++) begin
            if (candidate == (4'b0001 << i)) begin
               led_2_d = cnt_q[i];
            end
         end
`ifdef VOTING_TOTAL_EN
         if (candidate == 4'b0000) begin
            led_2_d = sat_total(cnt_q);
         end
`endif
      end else begin
         if (!button) begin
            voted_d = 1'b0;
            lock_d  = 1'b0;
         end else if (cand_ok && (candidate == cand_prev_q) && !voted_q && !lock_q) begin
            if (hold_q == HOLD_LAST) begin
               for (int i = 0; i < 4; i++) begin
                  if (candidate[i]) begin
                     cnt_d[i] = sat_inc(cnt_q[i]);
                  end
               end
               voted_d = 1'b1;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         led_1_d = voted_d ? 8'hFF : 8'h00;
      end
   end

   // Lock is set out of reset so a press interrupted by reset never counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         hold_q      <= '0;
         voted_q     <= 1'b0;
         lock_q      <= 1'b1;
         cand_prev_q <= 4'd0;
         led_1_q     <= 8'h00;
         led_2_q     <= 8'h00;
      end else begin
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         voted_q     <= voted_d;
         lock_q      <= lock_d;
         cand_prev_q <= cand_prev_d;
         led_1_q     <= led_1_d;
         led_2_q     <= led_2_d;
      end
   end

   assign led_1 = led_1_q;
   assign led_2 = led_2_q;

endmodule

// File: tb/tb_voting_machine.sv
// Scoreboard bench for voting_machine: stimulus queues expected LED values per clock edge, a monitor checks them.
module tb_voting_machine;

   localparam int H = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] candidate = 4'd0;
   logic       mode = 1'b0;
   logic       button = 1'b0;
   logic [7:0] led_1, led_2;

   voting_machine #(.HOLD_CYCLES(H)) dut (
      .clk(clk), .reset(reset), .candidate(candidate), .mode(mode),
      .button(button), .led_1(led_1), .led_2(led_2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      int         port;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   cnt[4];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] act;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         act = (e.port == 0) ? led_1 : led_2;
         total++;
         if (act !== e.val || e.cyc != cyc) begin
            bad++;
            $display("FAIL %s at edge %0d: led_%0d got=%h want=%h", e.name, e.cyc, e.port + 1, act, e.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int port, input logic [7:0] val, input string name);
      exp_t e;
      e.cyc = cyc;
      e.port = port;
      e.val = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      expect_out(0, 8'h00, "reset_led1");
      expect_out(1, 8'h00, "reset_led2");
      reset = 1'b0;
      for (int k = 0; k < 4; k++) cnt[k] = 0;
   endtask

   task automatic press(input logic [3:0] c, input int hi, input int lo, input bit chk);
      bit ok;
      ok = ($countones(c) == 1);
      candidate = c;
      button = 1'b0;
      step();
      if (chk) expect_out(0, 8'h00, "led1_idle");
      button = 1'b1;
      for (int i = 1; i <= hi; i++) begin
         step();
         if (chk) expect_out(0, (ok && i >= H) ? 8'hFF : 8'h00, "led1_hold");
      end
      button = 1'b0;
      for (int i = 1; i <= lo; i++) begin
         step();
         if (chk) expect_out(0, 8'h00, "led1_release");
      end
      if (ok && hi >= H) begin
         for (int k = 0; k < 4; k++) begin
            if (c[k] && cnt[k] < 255) cnt[k]++;
         end
      end
   endtask

   task automatic result(input logic [3:0] c, input logic [7:0] want, input string name);
      mode = 1'b1;
      candidate = c;
      step();
      expect_out(1, want, name);
      expect_out(0, 8'h00, "led1_result_mode");
      mode = 1'b0;
      step();
      expect_out(1, 8'h00, "led2_vote_mode");
   endtask

   initial begin
      logic [3:0] seq[25];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0011, 4'b0111, 4'b0011,
              4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
              4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0010,
              4'b0000};
      step();
      step();
      do_reset();

      press(4'b0001, 5, 5, 1);
      result(4'b0001, 8'd1, "single_c1");
      result(4'b0010, 8'd0, "single_c2");
      result(4'b1000, 8'd0, "single_c4");

      press(4'b0011, 5, 5, 1);
      press(4'b0111, 5, 5, 1);
      press(4'b0000, 5, 5, 1);
      result(4'b0001, 8'd1, "invalid_c1");
      result(4'b0011, 8'd0, "invalid_code_display");

      do_reset();
      for (int p = 0; p < 25; p++) press(seq[p], 5, 5, 1);
      result(4'b0001, 8'd4, "seq_c1");
      result(4'b0010, 8'd8, "seq_c2");
      result(4'b0100, 8'd6, "seq_c3");
      result(4'b1000, 8'd3, "seq_c4");
`ifdef VOTING_TOTAL_EN
      result(4'b0000, 8'd21, "seq_total");
`else
      result(4'b0000, 8'd0, "seq_zero_code");
`endif
      result(4'b0110, 8'd0, "seq_invalid_code");

      press(4'b0010, H - 1, 3, 1);
      result(4'b0010, 8'd8, "short_press");

      // Candidate switch mid-hold restarts the hold count; vote lands on the new candidate.
      candidate = 4'b0001;
      button = 1'b0;
      step();
      button = 1'b1;
      step();
      expect_out(0, 8'h00, "midhold_a");
      candidate = 4'b0010;
      step();
      expect_out(0, 8'h00, "midhold_b");
      step();
      expect_out(0, 8'h00, "midhold_c");
      step();
      expect_out(0, 8'hFF, "midhold_vote");
      step();
      expect_out(0, 8'hFF, "midhold_keep");
      button = 1'b0;
      step();
      expect_out(0, 8'h00, "midhold_release");
      cnt[1]++;
      result(4'b0010, 8'd9, "midhold_c2");
      result(4'b0001, 8'd4, "midhold_c1");

      // Mode change with the button held gives no vote.
      candidate = 4'b0100;
      button = 1'b0;
      step();
      button = 1'b1;
      step();
      expect_out(0, 8'h00, "modechg_hold");
      mode = 1'b1;
      step();
      expect_out(1, 8'd6, "modechg_display");
      expect_out(0, 8'h00, "modechg_led1");
      mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out(0, 8'h00, "modechg_no_vote");
      end
      button = 1'b0;
      step();
      result(4'b0100, 8'd6, "modechg_c3");

      for (int p = 0; p < 260; p++) press(4'b1000, 2, 1, 0);
      result(4'b1000, 8'd255, "sat_c4");
`ifdef VOTING_TOTAL_EN
      result(4'b0000, 8'd255, "sat_total");
`endif

      // Reset in the middle of a press: everything clears and the held press is discarded.
      candidate = 4'b1000;
      button = 1'b0;
      step();
      button = 1'b1;
      step();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out(0, 8'h00, "reset_press_discard");
      end
      button = 1'b0;
      step();
      result(4'b1000, 8'd0, "reset_c4");
      result(4'b0010, 8'd0, "reset_c2");
      press(4'b1000, 5, 5, 1);
      result(4'b1000, 8'(cnt[3]), "after_reset_vote");

      for (int i = 0; i < 10 && sb.size() > 0; i++) step();
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/voting_machine.md
# voting_machine

Four-candidate electronic voting counter for a single polling booth. In voting mode it registers one vote per officer-enabled button press for a one-hot selected candidate. In result mode it displays the stored tally of the selected candidate on an 8-bit LED bank. It sits between the booth's switch/button inputs and the LED display.

## Interface
- HOLD_CYCLES, default 2: consecutive cycles that `button` must be high, with a stable valid candidate, before a vote is accepted (minimum 1).
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high; clears all counts and outputs.
- candidate  input  4  one-hot candidate select: bit0 = candidate 1 … bit3 = candidate 4.
- mode  input  1  0 = voting, 1 = result display.
- button  input  1  booth-officer enable/press; high = machine armed for one vote.
- led_1  output  8  vote-accepted indicator.
- led_2  output  8  result display.

## Operation
- Internal state:
  - 8-bit counters `vote_count_1`..`vote_count_4`.
  - Hold counter.
  - `voted` latch, meaning a vote has already been taken in this press.
- Valid candidate: exactly one bit set. Values 0000, 0011, 0111 etc. are invalid and never counted.
- Voting mode (`mode` = 0):
  - The hold counter increments while `button`=1, the candidate is valid, the candidate is unchanged from the previous cycle, and `voted`=0.
  - Any violation of those conditions clears the hold counter.
  - When the hold counter reaches HOLD_CYCLES, the selected candidate's counter increments by 1 and `voted` sets.
  - `voted` clears only when `button`=0. Exactly one vote is taken per press regardless of hold length.
- Counters are 8-bit and saturate at 255; there is no wrap.
- `led_1` = 8'hFF while `voted`=1 in voting mode, otherwise 8'h00.
- Result mode (`mode` = 1):
  - No counter ever changes; the hold counter and `voted` are cleared.
  - `led_2` = count of the selected valid candidate.
  - `led_2` = 8'h00 for an invalid candidate (but see Configuration).
  - `led_1` = 8'h00.
- `led_2` = 8'h00 in voting mode.
- A mode change while `button` is held yields no vote. Returning to mode 0 requires `button` to be low before a new press counts.
- Reset: all counters, the hold counter, `voted`, `led_1` and `led_2` go to 0. Reset asserted mid-press discards the press.

## Timing
- All state and outputs are registered and update on the rising `clk` edge.
- With `button` rising before edge k, the vote count increments at edge k+HOLD_CYCLES−1. `led_1` goes 8'hFF on that same edge.
- `led_1` returns to 8'h00 on the first edge that samples `button`=0.
- `led_2` reflects the `mode`/`candidate` sampled at the previous edge: 1-cycle latency.
- When reset and other inputs are active on the same edge, reset wins.

## Configuration
- `VOTING_TOTAL_EN` defined:
  - In result mode with `candidate` = 4'b0000, `led_2` shows the sum of all four counters, 8-bit, saturating at 255.
  - Other invalid codes still show 8'h00.
- Undefined: 4'b0000 in result mode shows 8'h00; no total adder is built.

## Test plan
- Reset then single vote: assert reset 1 cycle; `candidate`=0001, `mode`=0, `button` high 5 cycles then low. Required: `vote_count_1`=1, others 0; `led_1`=FF from the accept edge until release.
- Invalid codes: presses with 0011, 0111, 0000 (5-cycle holds). Required: all counts unchanged; `led_1` stays 00.
- Full sequence of 25 presses, 5 cycles high / 5 low each, in this order: 1,2,3,3,3,(0011),(0111),(0011),2,1,4,3,1,2,2,2,3,2,4,1,2,4,3,2,(0000). Then result mode with 0001/0010/0100/1000. Required: `led_2` = 4, 8, 6, 3 respectively.
- Short press: `button` high for HOLD_CYCLES−1 cycles. Required: no vote. Changing the candidate mid-hold restarts the hold count.
- Saturation and reset: 260 valid presses for candidate 4. Required: `vote_count_4`=255. Reset asserted mid-press clears everything, and `led_2`=0 in result mode.
- With `VOTING_TOTAL_EN`: after the full sequence, result mode with `candidate`=0000. Required: `led_2`=21.
